qspi_arb: RTL and testbench
===========================

Name: qspi_arb

Overview:
- Arbitrates the single QSPI line-transfer engine between three requesters: icache line fill, dcache line fill and dcache dirty-line writeback.
- Latches the winning request's tag, direction and chip-select class, then holds them stable for the whole transfer.
- Routes the engine's nibble strobes back to the owning cache and returns a one-cycle completion pulse.
- Sits between icache/dcache and qspi in the vc top level, replacing the ad-hoc combinational req/i_d/write/mem/paddr muxing.

Parameters:
- PA, 24, physical address width.
- LINE_LENGTH, 4, cache line length in bytes; TW = PA-$clog2(LINE_LENGTH) is the tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rom_enable  in  1  boot ROM overlay enabled.
- i_pull  in  1  icache needs a line.
- i_tag  in  TW  icache line tag.
- d_push  in  1  dcache must write back a dirty line.
- d_pull  in  1  dcache needs a line.
- d_tag  in  TW  dcache line tag (writeback tag while d_push, fill tag otherwise).
- q_req  out  1  transfer request to qspi.
- q_ack  in  1  qspi accepted request (1-cycle pulse).
- q_done  in  1  qspi finished the line (1-cycle pulse).
- q_rstrobe_d  in  1  qspi wants next write nibble.
- q_wstrobe  in  1  qspi presents a read nibble.
- q_i_d  out  1  transfer is for icache.
- q_write  out  1  transfer is a writeback.
- q_mem  out  2  chip select class: 0 RAM0, 1 ROM, 2 RAM1.
- q_paddr  out  TW  latched line tag.
- wstrobe_i  out  1  read nibble strobe to icache.
- wstrobe_d  out  1  read nibble strobe to dcache.
- rstrobe_d  out  1  write nibble strobe to dcache.
- i_done  out  1  icache transfer complete pulse.
- d_done  out  1  dcache transfer complete pulse.
- busy  out  1  arbiter owns the engine (state != IDLE).

Behaviour:
- Reset (reset=0, async): state IDLE, rr=0 (icache favoured), d_lock=0. All outputs are 0, including q_paddr.
- FSM states: IDLE, ISSUE, XFER, DONE.
- IDLE, priority on a cycle where any request is high:
  1. d_push always wins.
  2. Else if d_lock=1 and d_pull=1, dcache fill wins.
  3. Else if i_pull and d_pull both high, rr selects: rr=0 gives icache, rr=1 gives dcache.
  4. Else the single requester wins.
- Grant cycle: latch own (I, DR or DW), q_paddr, q_i_d, q_write. Go to ISSUE next cycle. No grant in the same cycle as reset release.
- q_mem is latched at grant: 1 if rom_enable && !write; else {tag[TW-1],1'b0}, i.e. 2 when PA bit 23 is set, 0 otherwise. Writebacks therefore never target ROM.
- ISSUE: q_req=1 and all latched outputs valid. Stay in ISSUE until q_ack, then go to XFER; q_req drops the cycle after q_ack.
- XFER, strobe routing is combinational from the latched owner:
  - wstrobe_i = q_wstrobe && own==I.
  - wstrobe_d = q_wstrobe && own==DR.
  - rstrobe_d = q_rstrobe_d && own==DW.
  - Strobes are gated to 0 in every other state.
- XFER ends on q_done: go to DONE.
- DONE: one cycle of i_done (own==I) or d_done (own==DR/DW), then IDLE.
  - d_lock is set when a DW transfer completes and cleared when a DR transfer completes.
  - rr is set to 1 after an I grant completes and to 0 after a DR grant completes.
- Minimum turnaround: a request seen in IDLE gives q_req 1 cycle later. Back-to-back transfers have one IDLE cycle between DONE and the next ISSUE.
- A requester deasserting mid-transfer has no effect. The transfer cannot be aborted; it completes and the done pulse is still issued.
- Requests arriving while busy are held by the requester and arbitrated in the next IDLE.
- q_ack and q_done in the same cycle while in ISSUE: treated as ack; the done is ignored.
- q_done outside XFER is ignored.
- Tags may change after grant without effect.

Test Plan:
- Reset mid-XFER (own=DR), reset low for 2 cycles -> state IDLE and all outputs 0 immediately; the later q_done pulse is ignored; no done pulse.
- Lone i_pull, i_tag=22'h000010, rom_enable=1 -> q_req high 1 cycle later with q_i_d=1, q_write=0, q_mem=1, q_paddr=0x10. After q_ack, 8 q_wstrobe pulses reach wstrobe_i only. q_done is followed by i_done for exactly one cycle.
- d_push, d_pull and i_pull all high in IDLE, d_tag=22'h200004, rom_enable=1 -> DW granted with q_write=1, q_mem=2. After its d_done, the dcache fill is granted before the icache fill (d_lock). The icache fill is granted last.
- i_pull and d_pull held high continuously with no d_push -> grants alternate I, DR, I, DR. Neither requester waits more than one transfer.
- i_pull drops 2 cycles into XFER -> the transfer runs to q_done and i_done still pulses. The next IDLE grants nothing if no request is present.
- During a DW transfer, q_wstrobe pulses -> wstrobe_i and wstrobe_d stay 0. q_rstrobe_d pulses appear on rstrobe_d only.

Source files
------------

// File: rtl/qspi_arb.sv
// Arbitrates the QSPI line engine between icache fill, dcache fill and dcache writeback.
// Request in IDLE -> q_req next cycle; requesters hold requests while busy, engine paces via q_ack/q_done.
module qspi_arb #(
   parameter  int PA          = 24,
   parameter  int LINE_LENGTH = 4,
   localparam int TW          = PA - $clog2(LINE_LENGTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rom_enable,
   input  logic          i_pull,
   input  logic [TW-1:0] i_tag,
   input  logic          d_push,
   input  logic          d_pull,
   input  logic [TW-1:0] d_tag,
   output logic          q_req,
   input  logic          q_ack,
   input  logic          q_done,
   input  logic          q_rstrobe_d,
   input  logic          q_wstrobe,
   output logic          q_i_d,
   output logic          q_write,
   output logic [1:0]    q_mem,
   output logic [TW-1:0] q_paddr,
   output logic          wstrobe_i,
   output logic          wstrobe_d,
   output logic          rstrobe_d,
   output logic          i_done,
   output logic          d_done,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;
   typedef enum logic [1:0] {OWN_I, OWN_DR, OWN_DW} own_t;

   state_t        r_state;
   own_t          r_own;
   logic          r_rr;
   logic          r_lock;

   logic          w_any;
   own_t          w_pick;
   logic          w_write;
   logic [TW-1:0] w_tag;
   logic          w_xfer;

   // After a writeback the refill of the same line must go next, ahead of round-robin.
   always_comb begin
      w_any = i_pull | d_pull | d_push;
      if (d_push)
         w_pick = OWN_DW;
      else if (r_lock && d_pull)
         w_pick = OWN_DR;
      else if (i_pull && d_pull)
         w_pick = r_rr ? OWN_DR : OWN_I;
      else if (d_pull)
         w_pick = OWN_DR;
      else
         w_pick = OWN_I;
      w_write = (w_pick == OWN_DW);
      w_tag   = (w_pick == OWN_I) ? i_tag : d_tag;
   end

   assign w_xfer    = (r_state == S_XFER);
   assign wstrobe_i = q_wstrobe   && w_xfer && (r_own == OWN_I);
   assign wstrobe_d = q_wstrobe   && w_xfer && (r_own == OWN_DR);
   assign rstrobe_d = q_rstrobe_d && w_xfer && (r_own == OWN_DW);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_own   <= OWN_I;
         r_rr    <= 1'b0;
         r_lock  <= 1'b0;
         q_req   <= 1'b0;
         q_i_d   <= 1'b0;
         q_write <= 1'b0;
         q_mem   <= 2'd0;
         q_paddr <= '0;
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_own   <= w_pick;
                  q_paddr <= w_tag;
                  q_i_d   <= (w_pick == OWN_I);
                  q_write <= w_write;
                  // Writebacks never target the ROM overlay.
                  q_mem   <= (rom_enable && !w_write) ? 2'd1 : {w_tag[TW-1], 1'b0};
                  q_req   <= 1'b1;
                  busy    <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (q_ack) begin
                  q_req   <= 1'b0;
                  r_state <= S_XFER;
               end
            end
            S_XFER: begin
               if (q_done) begin
                  i_done  <= (r_own == OWN_I);
                  d_done  <= (r_own != OWN_I);
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               i_done  <= 1'b0;
               d_done  <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
               case (r_own)
                  OWN_I:   r_rr <= 1'b1;
                  OWN_DR: begin
                     r_rr   <= 1'b0;
                     r_lock <= 1'b0;
                  end
                  OWN_DW:  r_lock <= 1'b1;
                  default: r_lock <= r_lock;
               endcase
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_arb.sv
// Bench for qspi_arb: directed plan steps then randomized traffic against a transaction-level model.
module tb_qspi_arb;
   localparam int TW   = 22;
   localparam int O_NONE = 0;
   localparam int O_I    = 1;
   localparam int O_DR   = 2;
   localparam int O_DW   = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          rom_enable;
   logic          i_pull;
   logic [TW-1:0] i_tag;
   logic          d_push;
   logic          d_pull;
   logic [TW-1:0] d_tag;
   logic          q_req;
   logic          q_ack;
   logic          q_done;
   logic          q_rstrobe_d;
   logic          q_wstrobe;
   logic          q_i_d;
   logic          q_write;
   logic [1:0]    q_mem;
   logic [TW-1:0] q_paddr;
   logic          wstrobe_i;
   logic          wstrobe_d;
   logic          rstrobe_d;
   logic          i_done;
   logic          d_done;
   logic          busy;

   always #5 clk = ~clk;

   qspi_arb #(.PA(24), .LINE_LENGTH(4)) dut (
      .clk(clk), .reset(reset), .rom_enable(rom_enable),
      .i_pull(i_pull), .i_tag(i_tag), .d_push(d_push), .d_pull(d_pull), .d_tag(d_tag),
      .q_req(q_req), .q_ack(q_ack), .q_done(q_done), .q_rstrobe_d(q_rstrobe_d),
      .q_wstrobe(q_wstrobe), .q_i_d(q_i_d), .q_write(q_write), .q_mem(q_mem),
      .q_paddr(q_paddr), .wstrobe_i(wstrobe_i), .wstrobe_d(wstrobe_d),
      .rstrobe_d(rstrobe_d), .i_done(i_done), .d_done(d_done), .busy(busy)
   );

   int            n_chk  = 0;
   int            n_pass = 0;
   int            n_fail = 0;
   bit            m_rr;
   bit            m_lock;
   logic [TW-1:0] i_tag_v;
   logic [TW-1:0] dr_tag_v;
   logic [TW-1:0] dw_tag_v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Who should win, from the arbitration rules and the remembered fairness/lock history.
   function automatic int pick(input bit push, input bit dp, input bit ip);
      if (!push && !dp && !ip) return O_NONE;
      if (push) return O_DW;
      if (dp && (m_lock || !ip)) return O_DR;
      if (!dp) return O_I;
      return m_rr ? O_DR : O_I;
   endfunction

   function automatic logic [1:0] exp_mem(input logic [TW-1:0] t, input bit wr, input bit rom);
      if (rom && !wr) return 2'd1;
      return (t >= 22'h200000) ? 2'd2 : 2'd0;
   endfunction

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic drive_tags;
      i_tag = i_tag_v;
      d_tag = d_push ? dw_tag_v : dr_tag_v;
   endtask

   task automatic drop(input int own);
      if (own == O_I)  i_pull = 1'b0;
      if (own == O_DR) d_pull = 1'b0;
      if (own == O_DW) d_push = 1'b0;
      drive_tags();
   endtask

   // Entered at a negedge in IDLE with requests already driven; leaves at the next IDLE negedge.
   task automatic do_xfer(input int own, input int nib, input bit rnd, input bit early_drop, input bit keep);
      logic [TW-1:0] t;
      bit            wr;
      bit            ws;
      bit            rs;
      int            d;
      wr = (own == O_DW);
      t  = (own == O_I) ? i_tag_v : ((own == O_DW) ? dw_tag_v : dr_tag_v);
      tick();
      chk("grant_q_req", 32'(q_req), 32'(1'b1));
      chk("grant_busy",  32'(busy),  32'(1'b1));
      chk("grant_q_i_d", 32'(q_i_d), 32'(own == O_I));
      chk("grant_q_write", 32'(q_write), 32'(wr));
      chk("grant_q_mem", 32'(q_mem), 32'(exp_mem(t, wr, rom_enable)));
      chk("grant_q_paddr", 32'(q_paddr), 32'(t));
      if (rnd) begin
         i_tag = TW'($urandom);
         d_tag = TW'($urandom);
         d = $urandom_range(0, 2);
         repeat (d) begin
            tick();
            chk("issue_hold_q_req", 32'(q_req), 32'(1'b1));
         end
      end
      q_ack = 1'b1;
      if (rnd && $urandom_range(0, 3) == 0) q_done = 1'b1;
      tick();
      q_ack  = 1'b0;
      q_done = 1'b0;
      chk("ack_q_req_drop", 32'(q_req), 32'(1'b0));
      chk("ack_no_done", 32'({i_done, d_done}), 32'(2'b00));
      chk("xfer_busy", 32'(busy), 32'(1'b1));
      for (int k = 0; k < nib; k++) begin
         ws = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         rs = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         q_wstrobe   = ws;
         q_rstrobe_d = rs;
         #1;
         chk("route_wstrobe_i", 32'(wstrobe_i), 32'(ws && own == O_I));
         chk("route_wstrobe_d", 32'(wstrobe_d), 32'(ws && own == O_DR));
         chk("route_rstrobe_d", 32'(rstrobe_d), 32'(rs && own == O_DW));
         tick();
         q_wstrobe   = 1'b0;
         q_rstrobe_d = 1'b0;
         if (early_drop && k == 1) drop(own);
      end
      chk("xfer_paddr_stable", 32'(q_paddr), 32'(t));
      q_done = 1'b1;
      tick();
      q_done = 1'b0;
      chk("done_i_done", 32'(i_done), 32'(own == O_I));
      chk("done_d_done", 32'(d_done), 32'(own != O_I));
      q_wstrobe   = 1'b1;
      q_rstrobe_d = 1'b1;
      #1;
      chk("done_strobes_gated", 32'({wstrobe_i, wstrobe_d, rstrobe_d}), 32'(3'b000));
      q_wstrobe   = 1'b0;
      q_rstrobe_d = 1'b0;
      if (own == O_I) m_rr = 1'b1;
      if (own == O_DR) begin
         m_rr   = 1'b0;
         m_lock = 1'b0;
      end
      if (own == O_DW) m_lock = 1'b1;
      if (!keep) drop(own);
      drive_tags();
      tick();
      chk("done_one_cycle", 32'({i_done, d_done}), 32'(2'b00));
      chk("idle_busy", 32'(busy), 32'(1'b0));
      chk("idle_q_req", 32'(q_req), 32'(1'b0));
   endtask

   initial begin
      int own;
      reset = 1'b1; rom_enable = 1'b0; i_pull = 1'b0; d_push = 1'b0; d_pull = 1'b0;
      q_ack = 1'b0; q_done = 1'b0; q_rstrobe_d = 1'b0; q_wstrobe = 1'b0;
      i_tag_v = '0; dr_tag_v = '0; dw_tag_v = '0;
      m_rr = 1'b0; m_lock = 1'b0;
      drive_tags();
      #2 reset = 1'b0;
      tick();
      chk("reset_outputs", 32'({q_req, q_i_d, q_write, q_mem, wstrobe_i, wstrobe_d, rstrobe_d, i_done, d_done, busy}), 32'(0));
      chk("reset_q_paddr", 32'(q_paddr), 32'(0));
      reset = 1'b1;
      tick();

      // Lone icache fill with ROM overlay on.
      rom_enable = 1'b1; i_tag_v = 22'h000010; i_pull = 1'b1; drive_tags();
      do_xfer(O_I, 8, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a dcache fill.
      dr_tag_v = 22'h2abcde; d_pull = 1'b1; drive_tags();
      tick();
      chk("rst_pre_grant_q_req", 32'(q_req), 32'(1'b1));
      q_ack = 1'b1;
      tick();
      q_ack = 1'b0;
      q_wstrobe = 1'b1;
      #1;
      chk("rst_pre_wstrobe_d", 32'(wstrobe_d), 32'(1'b1));
      reset = 1'b0;
      #1;
      chk("rst_mid_outputs", 32'({q_req, q_i_d, q_write, q_mem, wstrobe_i, wstrobe_d, rstrobe_d, i_done, d_done, busy}), 32'(0));
      chk("rst_mid_q_paddr", 32'(q_paddr), 32'(0));
      q_wstrobe = 1'b0; d_pull = 1'b0; drive_tags();
      tick();
      tick();
      reset = 1'b1; m_rr = 1'b0; m_lock = 1'b0;
      q_done = 1'b1;
      tick();
      q_done = 1'b0;
      chk("rst_late_done_ignored", 32'({i_done, d_done, busy}), 32'(3'b000));
      tick();
      chk("rst_late_done_quiet", 32'({i_done, d_done, busy}), 32'(3'b000));

      // All three requesters: writeback, then locked refill, then icache.
      dw_tag_v = 22'h200004; dr_tag_v = 22'h000123; i_tag_v = 22'h000456;
      d_push = 1'b1; d_pull = 1'b1; i_pull = 1'b1; drive_tags();
      do_xfer(O_DW, 8, 1'b0, 1'b0, 1'b0);
      do_xfer(O_DR, 4, 1'b0, 1'b0, 1'b0);
      do_xfer(O_I,  4, 1'b0, 1'b0, 1'b0);

      // Both fills held high: alternate, starting with dcache since icache just went.
      i_pull = 1'b1; d_pull = 1'b1; drive_tags();
      do_xfer(O_DR, 2, 1'b0, 1'b0, 1'b1);
      do_xfer(O_I,  2, 1'b0, 1'b0, 1'b1);
      do_xfer(O_DR, 2, 1'b0, 1'b0, 1'b1);
      do_xfer(O_I,  2, 1'b0, 1'b0, 1'b1);
      i_pull = 1'b0; d_pull = 1'b0; drive_tags();

      // Requester withdraws mid-transfer; the transfer still completes.
      i_tag_v = 22'h1f0f0f; i_pull = 1'b1; drive_tags();
      do_xfer(O_I, 4, 1'b0, 1'b1, 1'b0);
      tick();
      chk("after_drop_no_grant", 32'({busy, q_req}), 32'(2'b00));

      // Randomized traffic.
      for (int it = 0; it < 60; it++) begin
         if (!i_pull && $urandom_range(0, 1) == 1) begin i_pull = 1'b1; i_tag_v = TW'($urandom); end
         if (!d_pull && $urandom_range(0, 1) == 1) begin d_pull = 1'b1; dr_tag_v = TW'($urandom); end
         if (!d_push && $urandom_range(0, 3) == 0) begin d_push = 1'b1; dw_tag_v = TW'($urandom); end
         rom_enable = 1'($urandom_range(0, 1));
         drive_tags();
         own = pick(d_push, d_pull, i_pull);
         if (own == O_NONE) begin
            tick();
            chk("rnd_idle", 32'({busy, q_req}), 32'(2'b00));
         end else begin
            do_xfer(own, $urandom_range(1, 8), 1'b1, 1'b0, 1'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
